tri_edge_sequencer: RTL and testbench
=====================================

Name: tri_edge_sequencer

Overview:
- Upstream feeder for the Bresenham line drawer in the wireframe path.
- Accepts one triangle (three signed screen-space vertices) via a valid/ready handshake and issues its three edges to the line drawer in order: v0→v1, v1→v2, v2→v0.
- For each edge it drives start/endpoint signals, waits for the drawer's done pulse, then moves to the next edge.
- Trivially rejects edges whose endpoints both lie outside the same screen boundary (outcode cull), so the drawer never walks lines that cannot be seen.

Parameters:
- COORD_WIDTH, 16, signed coordinate width; matches the line drawer.
- H_RES, 1280, screen width in pixels; the visible x range is 0..H_RES-1.
- V_RES, 720, screen height in pixels; the visible y range is 0..V_RES-1.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- tri_valid  in  1  triangle vertex data valid
- tri_ready  out  1  sequencer can accept a triangle
- tx0, ty0, tx1, ty1, tx2, ty2  in  COORD_WIDTH each, signed  triangle vertices
- line_start  out  1  one-cycle start pulse to the line drawer
- lx0, ly0, lx1, ly1  out  COORD_WIDTH each, signed  current edge endpoints
- line_done  in  1  drawer done pulse, one cycle
- busy  out  1  a triangle is in progress
- done  out  1  one-cycle pulse when all three edges are drawn or culled
- edges_culled  out  2  number of edges culled for the most recent triangle

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - tri_ready=1, line_start=0, busy=0, done=0, edges_culled=0.
  - lx0/ly0/lx1/ly1 and all latched vertices go to 0.
- Reset mid-operation aborts the triangle immediately with no done pulse. The line drawer shares rst_in, so the two blocks reset together.
- Handshake:
  - A triangle is accepted on a cycle where tri_valid && tri_ready.
  - All six coordinates are latched on acceptance.
  - tri_ready is high only in IDLE.
- States:
  - IDLE:
    - tri_ready=1 and busy=0.
    - On accept: edge_idx←0, edges_culled←0, busy←1, go to EVAL.
  - EVAL:
    - Select the edge endpoints by edge_idx: 0 gives (v0,v1), 1 gives (v1,v2), 2 gives (v2,v0). Register them onto lx0..ly1.
    - Compute a 4-bit outcode for each endpoint:
      - LEFT: x<0
      - RIGHT: x>H_RES-1
      - TOP: y<0
      - BOTTOM: y>V_RES-1
    - If (code_a & code_b) != 0, the edge is culled: edges_culled++ and go to ADVANCE.
    - Otherwise go to ISSUE.
    - Comparisons are signed at COORD_WIDTH bits.
  - ISSUE: line_start=1 for exactly this one cycle, then go to WAIT.
  - WAIT:
    - lx0..ly1 are held stable for the whole edge, because the drawer samples them across several cycles after start.
    - On line_done, go to ADVANCE.
  - ADVANCE:
    - If edge_idx==2: done=1 for one cycle, busy←0, go to IDLE.
    - Otherwise edge_idx++ and go to EVAL.
- Latency:
  - The accept cycle is cycle A. The first line_start is at cycle A+2.
  - After each line_done, the next line_start follows 3 cycles later.
  - Each culled edge costs 2 cycles (EVAL + ADVANCE).
  - A fully culled triangle gives its done pulse at A+6.
- A line_done seen outside WAIT is ignored.
- tri_valid seen while busy is not accepted, because tri_ready=0.
- A new triangle can be accepted the cycle after the done pulse.
- Degenerate edges (both endpoints identical) are issued normally; the drawer plots a single pixel.
- edges_culled holds its value until the next accept.

Decomposition:
- Shared package:
  - Outcode bit-position constants: OC_LEFT=0, OC_RIGHT=1, OC_TOP=2, OC_BOTTOM=3.
  - The state enum: IDLE, EVAL, ISSUE, WAIT, ADVANCE.
  - The H_RES/V_RES defaults.
- One sub-module, clip_outcode:
  - Purely combinational.
  - Inputs: x, y (signed COORD_WIDTH).
  - Output: a 4-bit outcode.
  - Instantiated twice, once per endpoint, and reusable by later clipping stages.

Test Plan:
- Visible triangle (10,10), (100,10), (50,80), connected to the real line drawer:
  - Edge endpoints must appear in order (10,10)→(100,10), (100,10)→(50,80), (50,80)→(10,10).
  - Exactly 3 line_start pulses, then one done pulse; edges_culled=0.
- Partial cull, triangle (-20,5), (-5,40), (30,30):
  - Edge 0 (both x<0) is culled.
  - Edges 1 and 2 are issued.
  - 2 line_start pulses; edges_culled=1.
- Full cull, triangle (2000,10), (1500,300), (1300,700), all x>1279:
  - No line_start pulses.
  - done asserted exactly 6 cycles after the accept cycle; edges_culled=3.
- Handshake:
  - Hold tri_valid=1 continuously with two different triangles queued.
  - The second triangle is accepted only the cycle after the first done pulse.
  - While busy, tri_ready stays 0 and the latched vertices do not change.
- Stability and spurious done:
  - Inject a line_done pulse in IDLE and in EVAL; both are ignored.
  - During WAIT, lx0..ly1 must not change on any cycle (checked by assertion).
- Reset mid-edge:
  - Assert rst_in for 1 cycle during WAIT of edge 1.
  - Next cycle: state is IDLE, tri_ready=1, busy=0, no done pulse, line_start=0.
  - A subsequent triangle completes normally.

Source files
------------

// File: rtl/tri_edge_sequencer_pkg.sv
// Shared types and constants for the triangle edge sequencer and its clipping helpers.
package tri_edge_sequencer_pkg;

    localparam int OC_LEFT   = 0;
    localparam int OC_RIGHT  = 1;
    localparam int OC_TOP    = 2;
    localparam int OC_BOTTOM = 3;
    localparam int OC_W      = 4;

    localparam int COORD_WIDTH_DEF = 16;
    localparam int H_RES_DEF       = 1280;
    localparam int V_RES_DEF       = 720;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        ISSUE,
        WAIT,
        ADVANCE
    } state_e;

    // Edges run v0->v1, v1->v2, v2->v0, so the far end wraps back to vertex 0.
    function automatic logic [1:0] edge_far(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/tri_edge_sequencer_if.sv
// Triangle input handshake plus line-drawer command/response bundle.
interface tri_edge_sequencer_if #(
    parameter int COORD_WIDTH = 16
);
    logic                          tri_valid;
    logic                          tri_ready;
    logic signed [COORD_WIDTH-1:0] tx0, ty0, tx1, ty1, tx2, ty2;
    logic                          line_start;
    logic signed [COORD_WIDTH-1:0] lx0, ly0, lx1, ly1;
    logic                          line_done;
    logic                          busy;
    logic                          done;
    logic [1:0]                    edges_culled;

    modport slave (
        input  tri_valid, tx0, ty0, tx1, ty1, tx2, ty2, line_done,
        output tri_ready, line_start, lx0, ly0, lx1, ly1, busy, done, edges_culled
    );

    modport master (
        output tri_valid, tx0, ty0, tx1, ty1, tx2, ty2, line_done,
        input  tri_ready, line_start, lx0, ly0, lx1, ly1, busy, done, edges_culled
    );
endinterface

// File: rtl/tri_edge_sequencer_clip_outcode.sv
// Cohen-Sutherland style region code for one point against the visible screen.
module clip_outcode
    import tri_edge_sequencer_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF
) (
    input  logic signed [COORD_WIDTH-1:0] x_i,
    input  logic signed [COORD_WIDTH-1:0] y_i,
    output logic        [OC_W-1:0]        code_o
);
    localparam logic signed [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(H_RES - 1);
    localparam logic signed [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(V_RES - 1);

    // Sign bit stands in for "< 0" so the compare stays signed at full width.
    always_comb begin
        code_o            = '0;
        code_o[OC_LEFT]   = x_i[COORD_WIDTH-1];
        code_o[OC_RIGHT]  = (x_i > X_MAX);
        code_o[OC_TOP]    = y_i[COORD_WIDTH-1];
        code_o[OC_BOTTOM] = (y_i > Y_MAX);
    end

endmodule

// File: rtl/tri_edge_sequencer.sv
// Walks the three edges of an accepted triangle, culling trivially invisible ones
// and handing the rest to the line drawer one at a time.
module tri_edge_sequencer
    import tri_edge_sequencer_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    tri_edge_sequencer_if.slave  seq_if
);
    typedef logic signed [COORD_WIDTH-1:0] coord_t;

    state_e     state_q, state_d;
    logic [1:0] edge_idx_q, edge_idx_d;
    logic [1:0] culled_q, culled_d;
    coord_t     vx_q [3];
    coord_t     vy_q [3];
    coord_t     lx0_q, ly0_q, lx1_q, ly1_q;

    coord_t          ax, ay, bx, by;
    logic [OC_W-1:0] code_a, code_b;
    logic            cull, accept;
    logic            tri_ready, busy, line_start, done;

    assign accept = seq_if.tri_valid && (state_q == IDLE);

    always_comb begin
        ax = vx_q[0];
        ay = vy_q[0];
        bx = vx_q[1];
        by = vy_q[1];
        case (edge_idx_q)
            2'd1: begin
                ax = vx_q[1]; ay = vy_q[1];
                bx = vx_q[edge_far(2'd1)]; by = vy_q[edge_far(2'd1)];
            end
            2'd2: begin
                ax = vx_q[2]; ay = vy_q[2];
                bx = vx_q[edge_far(2'd2)]; by = vy_q[edge_far(2'd2)];
            end
            default: ;
        endcase
    end

    clip_outcode #(.COORD_WIDTH(COORD_WIDTH), .H_RES(H_RES), .V_RES(V_RES)) u_oc_a (
        .x_i(ax), .y_i(ay), .code_o(code_a)
    );
    clip_outcode #(.COORD_WIDTH(COORD_WIDTH), .H_RES(H_RES), .V_RES(V_RES)) u_oc_b (
        .x_i(bx), .y_i(by), .code_o(code_b)
    );

    // Both endpoints beyond the same screen edge: nothing of the line can be visible.
    assign cull = |(code_a & code_b);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            edge_idx_q <= '0;
            culled_q   <= '0;
            lx0_q      <= '0;
            ly0_q      <= '0;
            lx1_q      <= '0;
            ly1_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            edge_idx_q <= edge_idx_d;
            culled_q   <= culled_d;
            if (accept) begin
                vx_q[0] <= seq_if.tx0; vy_q[0] <= seq_if.ty0;
                vx_q[1] <= seq_if.tx1; vy_q[1] <= seq_if.ty1;
                vx_q[2] <= seq_if.tx2; vy_q[2] <= seq_if.ty2;
            end
            // Endpoints load only in EVAL, so they stay frozen through ISSUE and WAIT.
            if (state_q == EVAL) begin
                lx0_q <= ax;
                ly0_q <= ay;
                lx1_q <= bx;
                ly1_q <= by;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_idx_d = edge_idx_q;
        culled_d   = culled_q;
        unique case (state_q)
            IDLE: begin
                if (seq_if.tri_valid) begin
                    state_d    = EVAL;
                    edge_idx_d = '0;
                    culled_d   = '0;
                end
            end
            EVAL: begin
                if (cull) begin
                    culled_d = culled_q + 2'd1;
                    state_d  = ADVANCE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (seq_if.line_done) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (edge_idx_q == 2'd2) begin
                    state_d = IDLE;
                end else begin
                    edge_idx_d = edge_idx_q + 2'd1;
                    state_d    = EVAL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tri_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        line_start = (state_q == ISSUE);
        done       = (state_q == ADVANCE) && (edge_idx_q == 2'd2);
    end

    assign seq_if.tri_ready    = tri_ready;
    assign seq_if.busy         = busy;
    assign seq_if.line_start   = line_start;
    assign seq_if.done         = done;
    assign seq_if.edges_culled = culled_q;
    assign seq_if.lx0          = lx0_q;
    assign seq_if.ly0          = ly0_q;
    assign seq_if.lx1          = lx1_q;
    assign seq_if.ly1          = ly1_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Scoreboard bench: a reference model predicts edge issues and completions per triangle.
module tb_tri_edge_sequencer;
    localparam int XMAX = 1279;
    localparam int YMAX = 719;

    typedef struct { int cyc; int x0; int y0; int x1; int y1; } start_t;
    typedef struct { int cyc; int culled; } done_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    tri_edge_sequencer_if #(.COORD_WIDTH(16)) bif ();

    tri_edge_sequencer #(.COORD_WIDTH(16), .H_RES(1280), .V_RES(720)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .seq_if (bif)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    start_t sq[$];
    done_t  dq[$];
    int     lat_q[$];
    int     tri_lat = 1;
    int     win_lo = 0, win_hi = -1;
    int     errors = 0, checks = 0, stim_to = 0;
    bit     fin_req = 0, fin_ack = 0;

    // Line drawer stand-in: done pulse comes 'lat' cycles after each start.
    int   drw_cnt = 0;
    logic spur = 1'b0;
    always @(posedge clk_in) begin
        if (rst_in) drw_cnt <= 0;
        else if (bif.line_start) begin
            if (lat_q.size() != 0) drw_cnt <= lat_q.pop_front();
            else drw_cnt <= 1;
        end else if (drw_cnt != 0) drw_cnt <= drw_cnt - 1;
    end
    assign bif.line_done = (drw_cnt == 1) || spur;

    function automatic bit edge_hidden(input int xa, input int ya, input int xb, input int yb);
        return (xa < 0 && xb < 0) || (xa > XMAX && xb > XMAX) ||
               (ya < 0 && yb < 0) || (ya > YMAX && yb > YMAX);
    endfunction

    // Reference model: walk the edges on a cycle timeline at accept time.
    always @(negedge clk_in) begin
        int vx[3];
        int vy[3];
        int t, nc, b;
        if (!rst_in && bif.tri_valid && bif.tri_ready) begin
            vx[0] = int'(bif.tx0); vy[0] = int'(bif.ty0);
            vx[1] = int'(bif.tx1); vy[1] = int'(bif.ty1);
            vx[2] = int'(bif.tx2); vy[2] = int'(bif.ty2);
            t  = cyc;
            nc = 0;
            for (int e = 0; e < 3; e++) begin
                b = (e + 1) % 3;
                t = t + 1;
                if (edge_hidden(vx[e], vy[e], vx[b], vy[b])) begin
                    nc = nc + 1;
                    t  = t + 1;
                end else begin
                    t = t + 1;
                    sq.push_back('{t, vx[e], vy[e], vx[b], vy[b]});
                    lat_q.push_back(tri_lat);
                    t = t + tri_lat + 1;
                end
            end
            dq.push_back('{t, nc});
            win_lo = cyc;
            win_hi = t;
        end
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    bit          post_rst = 0, in_edge = 0, vad = 0;
    int          last_done = -10;
    logic [63:0] held;

    always @(negedge clk_in) begin
        start_t s;
        done_t  d;
        bit     eb;
        if (rst_in) begin
            post_rst = 1;
            in_edge  = 0;
            vad      = 0;
        end else begin
            if (post_rst) begin
                post_rst = 0;
                chk("rst_tri_ready", bif.tri_ready, 1);
                chk("rst_busy", bif.busy, 0);
                chk("rst_done", bif.done, 0);
                chk("rst_line_start", bif.line_start, 0);
                chk("rst_edges_culled", bif.edges_culled, 0);
                chk("rst_lxy", {bif.lx0, bif.ly0, bif.lx1, bif.ly1}, 0);
            end
            eb = (cyc > win_lo) && (cyc <= win_hi);
            chk("busy", bif.busy, eb);
            chk("tri_ready", bif.tri_ready, !eb);
            if (bif.line_start) begin
                if (sq.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    s = sq.pop_front();
                    chk("start_cyc", cyc, s.cyc);
                    chk("lx0", bif.lx0, s.x0);
                    chk("ly0", bif.ly0, s.y0);
                    chk("lx1", bif.lx1, s.x1);
                    chk("ly1", bif.ly1, s.y1);
                end
                in_edge = 1;
                held    = {bif.lx0, bif.ly0, bif.lx1, bif.ly1};
            end else if (in_edge) begin
                chk("wait_stable", {bif.lx0, bif.ly0, bif.lx1, bif.ly1}, held);
                if (bif.line_done) in_edge = 0;
            end
            if (bif.done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    d = dq.pop_front();
                    chk("done_cyc", cyc, d.cyc);
                    chk("edges_culled", bif.edges_culled, d.culled);
                end
                last_done = cyc;
                vad       = bif.tri_valid;
            end
            if (bif.tri_valid && bif.tri_ready) begin
                if (vad) chk("b2b_accept_cyc", cyc, last_done + 1);
                vad = 0;
            end
            if (fin_req && !fin_ack) begin
                chk("drain_starts", sq.size(), 0);
                chk("drain_dones", dq.size(), 0);
                chk("stim_timeouts", stim_to, 0);
                fin_ack = 1;
            end
        end
    end

    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input int lat);
        int n;
        bif.tx0 = 16'(x0); bif.ty0 = 16'(y0);
        bif.tx1 = 16'(x1); bif.ty1 = 16'(y1);
        bif.tx2 = 16'(x2); bif.ty2 = 16'(y2);
        tri_lat       = lat;
        bif.tri_valid = 1'b1;
        n = 0;
        @(negedge clk_in);
        while (!bif.tri_ready && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 500) stim_to++;
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input int n);
        bif.tri_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    function automatic int rc(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo, 0));
    endfunction

    function automatic int rx();
        int r;
        r = int'($urandom_range(9, 0));
        if (r == 0) return (int'($urandom_range(1, 0)) == 0) ? -32768 : 32767;
        if (r == 1) return (int'($urandom_range(1, 0)) == 0) ? -1 : 1280;
        return rc(-200, 1480);
    endfunction

    function automatic int ry();
        int r;
        r = int'($urandom_range(9, 0));
        if (r == 0) return (int'($urandom_range(1, 0)) == 0) ? -32768 : 32767;
        if (r == 1) return (int'($urandom_range(1, 0)) == 0) ? -1 : 720;
        return rc(-200, 920);
    endfunction

    initial begin
        int n;
        bif.tri_valid = 1'b0;
        bif.tx0 = '0; bif.ty0 = '0; bif.tx1 = '0;
        bif.ty1 = '0; bif.tx2 = '0; bif.ty2 = '0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        idle(2);

        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(1);

        send(10, 10, 100, 10, 50, 80, 3);
        spur = 1'b1;
        bif.tri_valid = 1'b0;
        @(posedge clk_in); #1;
        spur = 1'b0;
        idle(25);

        send(-20, 5, -5, 40, 30, 30, 2);
        idle(20);
        send(2000, 10, 1500, 300, 1300, 700, 1);
        idle(10);
        send(1279, 719, 1280, 720, 1280, 0, 2);
        idle(15);
        send(5, 5, 5, 5, 700, 700, 1);
        idle(15);
        send(0, 0, -1, -1, -1, 5, 1);
        idle(15);

        send(100, 100, 200, 200, 300, 100, 2);
        send(-50, -50, -10, -60, 600, -1, 4);
        idle(30);

        // Abort during the second edge's WAIT, then confirm a clean restart.
        send(20, 20, 400, 30, 200, 300, 20);
        bif.tri_valid = 1'b0;
        repeat (28) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        sq.delete();
        dq.delete();
        lat_q.delete();
        win_hi = -1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle(3);
        send(30, 30, 60, 30, 45, 60, 2);
        idle(20);

        for (int i = 0; i < 40; i++) begin
            send(rx(), ry(), rx(), ry(), rx(), ry(), int'($urandom_range(6, 1)));
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 0)));
        end
        idle(1);

        n = 0;
        while (dq.size() != 0 && n < 3000) begin
            @(posedge clk_in); #1;
            n++;
        end
        fin_req = 1;
        repeat (3) @(posedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
